attempt_lockout_ctrl: RTL and testbench

ATTEMPT_LOCKOUT_CTRL -- requirements
Module: attempt_lockout_ctrl

---
 rtl/attempt_lockout_ctrl.sv | 101 ++++++++++
 tb/tb_attempt_lockout_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/attempt_lockout_ctrl.sv
// Attempt lockout controller: opens the door on a correct attempt and locks out
// further attempts for a fixed time after MAX_FAIL consecutive wrong attempts.
module attempt_lockout_ctrl #(
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          unlock,
  input  logic                          pwd_incorrect,
  output logic                          entry_enable,
  output logic                          door_open,
  output logic                          locked_out,
  output logic                          alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
  output logic [7:0]                    lockout_events
);

  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int MAXC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);

  generate
    if (MAX_FAIL < 1 || OPEN_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_param_check
      $error("attempt_lockout_ctrl: MAX_FAIL, OPEN_CYCLES and LOCK_CYCLES must all be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      fail_count     <= '0;
      lockout_events <= '0;
      alarm          <= 1'b0;
    end else begin
      alarm <= 1'b0;
      case (state)
        IDLE: begin
          // A wrong attempt wins over a simultaneous correct one.
          if (pwd_incorrect) begin
            if (int'(fail_count) + 1 >= MAX_FAIL) begin
              state      <= LOCKOUT;
              timer      <= LOCK_LOAD;
              fail_count <= FAIL_MAX;
              alarm      <= 1'b1;
              if (lockout_events != 8'hFF) begin
                lockout_events <= lockout_events + 8'd1;
              end
            end else begin
              fail_count <= fail_count + FW'(1);
            end
          end else if (unlock) begin
            state      <= OPEN;
            timer      <= OPEN_LOAD;
            fail_count <= '0;
          end
        end
        OPEN: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state      <= IDLE;
            fail_count <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the registered state.
  assign entry_enable = (state == IDLE);
  assign door_open    = (state == OPEN);
  assign locked_out   = (state == LOCKOUT);

endmodule

// File: tb/tb_attempt_lockout_ctrl.sv
// Self-checking bench for attempt_lockout_ctrl: directed scenarios plus random
// pulses, compared each cycle against a remaining-cycles reference model.
module tb_attempt_lockout_ctrl;

  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYCLES = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int FW          = $clog2(MAX_FAIL + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          unlock = 1'b0;
  logic          pwd_incorrect = 1'b0;
  logic          entry_enable;
  logic          door_open;
  logic          locked_out;
  logic          alarm;
  logic [FW-1:0] fail_count;
  logic [7:0]    lockout_events;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of door-open / lockout still owed, plus counters.
  int m_open_left = 0;
  int m_lock_left = 0;
  int m_fail      = 0;
  int m_events    = 0;
  int m_alarm     = 0;

  // Per-scenario observation counters.
  int cnt_door  = 0;
  int cnt_lock  = 0;
  int cnt_alarm = 0;

  attempt_lockout_ctrl #(
    .MAX_FAIL(MAX_FAIL),
    .OPEN_CYCLES(OPEN_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .unlock(unlock),
    .pwd_incorrect(pwd_incorrect),
    .entry_enable(entry_enable),
    .door_open(door_open),
    .locked_out(locked_out),
    .alarm(alarm),
    .fail_count(fail_count),
    .lockout_events(lockout_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_open_left = 0;
    m_lock_left = 0;
    m_fail      = 0;
    m_events    = 0;
    m_alarm     = 0;
  endtask

  task automatic model_edge(input bit u, input bit p);
    m_alarm = 0;
    if (m_open_left > 0) begin
      m_open_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (p) begin
      if (m_fail + 1 >= MAX_FAIL) begin
        m_fail      = MAX_FAIL;
        m_lock_left = LOCK_CYCLES;
        m_alarm     = 1;
        if (m_events < 255) m_events++;
      end else begin
        m_fail++;
      end
    end else if (u) begin
      m_open_left = OPEN_CYCLES;
      m_fail      = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".door_open"},      32'(door_open),      32'(m_open_left > 0));
    chk({tag, ".locked_out"},     32'(locked_out),     32'(m_lock_left > 0));
    chk({tag, ".entry_enable"},   32'(entry_enable),   32'(m_open_left == 0 && m_lock_left == 0));
    chk({tag, ".alarm"},          32'(alarm),          32'(m_alarm));
    chk({tag, ".fail_count"},     32'(fail_count),     32'(m_fail));
    chk({tag, ".lockout_events"}, 32'(lockout_events), 32'(m_events));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic step(input string tag, input bit u, input bit p);
    unlock        = u;
    pwd_incorrect = p;
    @(posedge clk);
    model_edge(u, p);
    #1;
    unlock        = 1'b0;
    pwd_incorrect = 1'b0;
    check_all(tag);
    if (door_open === 1'b1)  cnt_door++;
    if (locked_out === 1'b1) cnt_lock++;
    if (alarm === 1'b1)      cnt_alarm++;
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    cnt_door  = 0;
    cnt_lock  = 0;
    cnt_alarm = 0;
  endtask

  initial begin
    // Reset state, observed while reset is held and before any clock edge.
    model_reset();
    #2;
    check_all("reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset_release");

    // Correct attempt: door open for exactly OPEN_CYCLES cycles.
    clear_counts();
    step("unlock", 1'b1, 1'b0);
    idle_steps("open_run", OPEN_CYCLES + 2);
    chk("open_len", 32'(cnt_door), 32'(OPEN_CYCLES));
    chk("open_no_alarm", 32'(cnt_alarm), 32'd0);

    // Three wrong attempts two cycles apart: lockout for LOCK_CYCLES cycles.
    clear_counts();
    step("bad1", 1'b0, 1'b1);
    chk("bad1_fail", 32'(fail_count), 32'd1);
    step("gap1", 1'b0, 1'b0);
    step("bad2", 1'b0, 1'b1);
    chk("bad2_fail", 32'(fail_count), 32'd2);
    step("gap2", 1'b0, 1'b0);
    step("bad3", 1'b0, 1'b1);
    chk("bad3_fail", 32'(fail_count), 32'(MAX_FAIL));
    idle_steps("lock_run", LOCK_CYCLES + 2);
    chk("lock_len", 32'(cnt_lock), 32'(LOCK_CYCLES));
    chk("lock_alarm_cnt", 32'(cnt_alarm), 32'd1);
    chk("lock_events", 32'(lockout_events), 32'd1);
    chk("lock_exit_fail", 32'(fail_count), 32'd0);

    // Two wrong attempts then a correct one: count clears, no alarm.
    clear_counts();
    step("pre_bad1", 1'b0, 1'b1);
    step("pre_bad2", 1'b0, 1'b1);
    step("good", 1'b1, 1'b0);
    chk("good_fail", 32'(fail_count), 32'd0);
    idle_steps("good_run", OPEN_CYCLES + 1);
    chk("good_open_len", 32'(cnt_door), 32'(OPEN_CYCLES));
    chk("good_no_alarm", 32'(cnt_alarm), 32'd0);

    // Simultaneous pulses at fail_count=2: wrong attempt takes priority.
    clear_counts();
    step("sim_bad1", 1'b0, 1'b1);
    step("sim_bad2", 1'b0, 1'b1);
    step("sim_both", 1'b1, 1'b1);
    chk("sim_alarm", 32'(alarm), 32'd1);
    chk("sim_door", 32'(door_open), 32'd0);
    idle_steps("sim_run", LOCK_CYCLES);
    chk("sim_door_total", 32'(cnt_door), 32'd0);

    // Pulses during OPEN are ignored; first IDLE-cycle pulse is honoured.
    clear_counts();
    step("inj_open", 1'b1, 1'b0);
    for (int i = 0; i < OPEN_CYCLES; i++) step("inj_open_noise", 1'($urandom), 1'($urandom));
    chk("inj_open_len", 32'(cnt_door), 32'(OPEN_CYCLES));
    step("first_idle_bad", 1'b0, 1'b1);
    chk("first_idle_fail", 32'(fail_count), 32'd1);

    // Pulses during LOCKOUT are ignored; first IDLE-cycle unlock is honoured.
    clear_counts();
    step("inj_bad2", 1'b0, 1'b1);
    step("inj_bad3", 1'b0, 1'b1);
    for (int i = 0; i < LOCK_CYCLES; i++) step("inj_lock_noise", 1'($urandom), 1'($urandom));
    chk("inj_lock_len", 32'(cnt_lock), 32'(LOCK_CYCLES));
    step("first_idle_unlock", 1'b1, 1'b0);
    chk("first_idle_door", 32'(door_open), 32'd1);
    idle_steps("drain", OPEN_CYCLES);

    // Randomized pulses against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
    end
    idle_steps("rand_drain", LOCK_CYCLES + 1);

    // Asynchronous reset five cycles into LOCKOUT.
    for (int i = 0; i < MAX_FAIL; i++) step("pre_rst_bad", 1'b0, 1'b1);
    idle_steps("pre_rst_lock", 4);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_counts();
    step("post_rst", 1'b0, 1'b0);
    idle_steps("post_rst_idle", 3);
    chk("post_rst_no_lock", 32'(cnt_lock), 32'd0);

    // 256 forced lockouts: event counter saturates at 255.
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < MAX_FAIL; i++) step("sat_bad", 1'b0, 1'b1);
      idle_steps("sat_wait", LOCK_CYCLES);
    end
    chk("sat_events", 32'(lockout_events), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
